// File: rtl/pipe_stage_slot_pkg.sv
// Shared widths, sideband field layout and reset value for the pipeline-stage slots.
// Every stage currently carries the same payload and {pc, BD} sideband widths.
package pipe_stage_slot_pkg;

  localparam int PIPE_DATA_W = 192;
  localparam int PIPE_SIDE_W = 33;

  // Sideband layout: {pc[31:0], BD}
  localparam int PC_LSB = 1;
  localparam int BD_BIT = 0;

  localparam logic [PIPE_SIDE_W-1:0] PIPE_SIDE_RST = '0;

  typedef enum logic [1:0] {
    STAGE_IF_ID,
    STAGE_ID_EX,
    STAGE_EX_MEM,
    STAGE_MEM_WB
  } pipe_stage_e;

  function automatic logic [PIPE_SIDE_W-1:0] pack_side(input logic [31:0] pc, input logic bd);
    logic [PIPE_SIDE_W-1:0] s;
    s = '0;
    s[PC_LSB +: 32] = pc;
    s[BD_BIT] = bd;
    return s;
  endfunction

endpackage

// File: rtl/pipe_stage_slot_entry.sv
// One {valid, data, side} storage entry of a pipeline slot.
// The three fields have independent load enables; clear only affects valid.
module pipe_stage_slot_entry
  import pipe_stage_slot_pkg::*;
#(
  parameter int                DATA_W   = PIPE_DATA_W,
  parameter int                SIDE_W   = PIPE_SIDE_W,
  parameter logic [SIDE_W-1:0] SIDE_RST = PIPE_SIDE_RST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              valid_load,
  input  logic              valid_in,
  input  logic              data_load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              side_load,
  input  logic [SIDE_W-1:0] side_in,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [SIDE_W-1:0] side
);

  // clear beats valid_load so a flush always empties the entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
      side  <= SIDE_RST;
    end else begin
      if (clear) begin
        valid <= 1'b0;
      end else if (valid_load) begin
        valid <= valid_in;
      end
      if (data_load) begin
        data <= data_in;
      end
      if (side_load) begin
        side <= side_in;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_slot.sv
// Generic pipeline-stage register with valid/allowin handshake, ready_go and flush.
// Define PIPE_SKID_EN to add a skid entry and make in_allowin a pure flop output.
module pipe_stage_slot
  import pipe_stage_slot_pkg::*;
#(
  parameter int                DATA_W   = PIPE_DATA_W,
  parameter int                SIDE_W   = PIPE_SIDE_W,
  parameter logic [SIDE_W-1:0] SIDE_RST = PIPE_SIDE_RST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_allowin,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SIDE_W-1:0] in_side,
  input  logic              ready_go,
  input  logic              out_allowin,
  output logic              out_valid,
  output logic              out_fire,
  output logic [DATA_W-1:0] out_data,
  output logic [SIDE_W-1:0] out_side,
  output logic [1:0]        occ
);

  logic              head_valid;
  logic [DATA_W-1:0] head_data;
  logic [SIDE_W-1:0] head_side;
  logic              head_take;
  logic              accept;

  assign out_fire  = head_valid & ready_go & out_allowin;
  assign head_take = ~head_valid | out_fire;
  assign accept    = in_valid & in_allowin & ~flush;

  assign out_valid = head_valid;
  assign out_data  = head_data;
  assign out_side  = head_side;

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [SIDE_W-1:0] skid_side;
  logic              skid_load;

  assign in_allowin = ~skid_valid;
  assign skid_load  = accept & ~head_take;
  assign occ        = {1'b0, head_valid} + {1'b0, skid_valid};

  // When the head frees up, an older beat parked in the skid entry always goes first
  pipe_stage_slot_entry #(
    .DATA_W   (DATA_W),
    .SIDE_W   (SIDE_W),
    .SIDE_RST (SIDE_RST)
  ) u_head (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .valid_load (head_take),
    .valid_in   (skid_valid | in_valid),
    .data_load  (head_take & (skid_valid | accept)),
    .data_in    (skid_valid ? skid_data : in_data),
    .side_load  (head_take),
    .side_in    (skid_valid ? skid_side : in_side),
    .valid      (head_valid),
    .data       (head_data),
    .side       (head_side)
  );

  pipe_stage_slot_entry #(
    .DATA_W   (DATA_W),
    .SIDE_W   (SIDE_W),
    .SIDE_RST (SIDE_RST)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush | (head_take & skid_valid)),
    .valid_load (skid_load),
    .valid_in   (1'b1),
    .data_load  (skid_load),
    .data_in    (in_data),
    .side_load  (skid_load),
    .side_in    (in_side),
    .valid      (skid_valid),
    .data       (skid_data),
    .side       (skid_side)
  );
`else
  assign in_allowin = ~head_valid | (ready_go & out_allowin);
  assign occ        = {1'b0, head_valid};

  // Side follows in_allowin even for bubbles so a bubble's pc/BD stays reportable
  pipe_stage_slot_entry #(
    .DATA_W   (DATA_W),
    .SIDE_W   (SIDE_W),
    .SIDE_RST (SIDE_RST)
  ) u_head (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .valid_load (in_allowin),
    .valid_in   (in_valid),
    .data_load  (accept),
    .data_in    (in_data),
    .side_load  (in_allowin),
    .side_in    (in_side),
    .valid      (head_valid),
    .data       (head_data),
    .side       (head_side)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_slot.sv
// Self-checking bench for pipe_stage_slot: queue-based reference model plus directed vectors.
// Works in both the base build and with PIPE_SKID_EN defined.
module tb_pipe_stage_slot;

  localparam int DW = 32;
  localparam int SW = 33;
  localparam logic [SW-1:0] SRST = 33'h1_2345_6789;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_allowin;
  logic [DW-1:0] in_data;
  logic [SW-1:0] in_side;
  logic          ready_go;
  logic          out_allowin;
  logic          out_valid;
  logic          out_fire;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_side;
  logic [1:0]    occ;

  pipe_stage_slot #(
    .DATA_W   (DW),
    .SIDE_W   (SW),
    .SIDE_RST (SRST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_allowin  (in_allowin),
    .in_data     (in_data),
    .in_side     (in_side),
    .ready_go    (ready_go),
    .out_allowin (out_allowin),
    .out_valid   (out_valid),
    .out_fire    (out_fire),
    .out_data    (out_data),
    .out_side    (out_side),
    .occ         (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] side;
  } beat_t;

  // Reference: a FIFO of held beats (capacity 1, or 2 with skid) plus the head registers
  beat_t         mq[$];
  logic [DW-1:0] m_data = '0;
  logic [SW-1:0] m_side = SRST;
  int            checks = 0;
  int            failures = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Compare on the falling edge, then advance the model to the state after the next rising edge
  always @(negedge clk) begin : cmp
    int    sz;
    bit    allow, fire, acc, take;
    beat_t b;
    if (!reset) begin
      mq.delete();
      m_data = '0;
      m_side = SRST;
    end
    sz    = mq.size();
    fire  = (sz > 0) && ready_go && out_allowin;
    allow = SKID ? (sz < 2) : ((sz == 0) || (ready_go && out_allowin));
    check_output("m_out_valid", 64'(out_valid), 64'(sz > 0));
    check_output("m_occ", 64'(occ), 64'(sz));
    check_output("m_in_allowin", 64'(in_allowin), 64'(allow));
    check_output("m_out_fire", 64'(out_fire), 64'(fire));
    check_output("m_out_data", 64'(out_data), 64'(m_data));
    check_output("m_out_side", 64'(out_side), 64'(m_side));
    if (reset) begin
      acc  = in_valid && allow && !flush;
      take = (sz == 0) || fire;
      if (take) begin
        if (sz == 2) begin
          m_data = mq[1].data;
          m_side = mq[1].side;
        end else begin
          m_side = in_side;
          if (acc) m_data = in_data;
        end
      end
      if (fire) void'(mq.pop_front());
      if (acc) begin
        b.data = in_data;
        b.side = in_side;
        mq.push_back(b);
      end
      if (flush) mq.delete();
    end
  end

  task automatic apply_stimulus(input logic v, input logic [DW-1:0] d, input logic [SW-1:0] s,
                                input logic rg, input logic oa, input logic fl);
    in_valid    = v;
    in_data     = d;
    in_side     = s;
    ready_go    = rg;
    out_allowin = oa;
    flush       = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic took;
    reset = 1'b1;
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    #1 reset = 1'b0;
    #1;
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_occ", 64'(occ), 64'd0);
    check_output("rst_out_side", 64'(out_side), 64'(SRST));
    check_output("rst_out_data", 64'(out_data), 64'd0);
    check_output("rst_in_allowin", 64'(in_allowin), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Back-to-back stream 1..8
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(1'b1, DW'(i), SW'(i * 2), 1'b1, 1'b1, 1'b0);
      step();
      check_output("stream_data", 64'(out_data), 64'(i));
      check_output("stream_occ", 64'(occ), 64'd1);
      check_output("stream_allowin", 64'(in_allowin), 64'd1);
    end
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    step();
    check_output("drain_valid", 64'(out_valid), 64'd0);

    // Stall with head 0x5, upstream offering 0x6 until accepted
    apply_stimulus(1'b1, 32'h5, 33'h50, 1'b1, 1'b1, 1'b0);
    step();
    check_output("stall_head", 64'(out_data), 64'h5);
    apply_stimulus(1'b1, 32'h6, 33'h60, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      took = in_allowin & in_valid;
      check_output("stall_data", 64'(out_data), 64'h5);
      check_output("stall_fire", 64'(out_fire), 64'd0);
      check_output("stall_allowin", 64'(in_allowin), 64'(SKID && k == 0));
      check_output("stall_occ", 64'(occ), (SKID && k > 0) ? 64'd2 : 64'd1);
      step();
      if (took) in_valid = 1'b0;
    end
    ready_go = 1'b1;
    @(negedge clk);
    took = in_allowin & in_valid;
    check_output("release_fire", 64'(out_fire), 64'd1);
    check_output("release_data", 64'(out_data), 64'h5);
    step();
    if (took) in_valid = 1'b0;
    check_output("release_next", 64'(out_data), 64'h6);
    check_output("release_valid", 64'(out_valid), 64'd1);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    step();
    check_output("release_empty", 64'(occ), 64'd0);

    // Flush while the head fires and a new beat arrives
    apply_stimulus(1'b1, 32'h9, 33'h90, 1'b0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b1, 32'hA, 33'h1_7F80_0700, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check_output("flush_fire", 64'(out_fire), 64'd1);
    check_output("flush_fire_data", 64'(out_data), 64'h9);
    step();
    check_output("flush_valid", 64'(out_valid), 64'd0);
    check_output("flush_occ", 64'(occ), 64'd0);
    check_output("flush_side", 64'(out_side), 64'h1_7F80_0700);

    // Bubble still updates the sideband
    apply_stimulus(1'b0, 32'hB, 33'h0_0080_0021, 1'b1, 1'b1, 1'b0);
    step();
    check_output("bubble_valid", 64'(out_valid), 64'd0);
    check_output("bubble_side", 64'(out_side), 64'h0_0080_0021);
    check_output("bubble_data", 64'(out_data), 64'h9);

    // Asynchronous reset in the middle of a stall
    apply_stimulus(1'b1, 32'h11, 33'h110, 1'b0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b1, 32'h12, 33'h120, 1'b0, 1'b1, 1'b0);
    step();
    check_output("prerst_occ", 64'(occ), SKID ? 64'd2 : 64'd1);
    check_output("prerst_data", 64'(out_data), 64'h11);
    #2 reset = 1'b0;
    #1;
    check_output("arst_valid", 64'(out_valid), 64'd0);
    check_output("arst_occ", 64'(occ), 64'd0);
    check_output("arst_side", 64'(out_side), 64'(SRST));
    check_output("arst_allowin", 64'(in_allowin), 64'd1);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    step();
    reset = 1'b1;

    // Random traffic with occasional flushes
    for (int n = 0; n < 400; n++) begin
      apply_stimulus(1'($urandom_range(0, 1)), DW'($urandom), {1'($urandom_range(0, 1)), 32'($urandom)},
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 5));
      step();
    end

    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
